// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: saturates the input to the digit range and runs
// one double-dabble step per clock, publishing a held BCD word plus the matching binary.
module bin_to_bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int SAT_VAL = 9999
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic [BIN_W-1:0]      binIn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic [BIN_W-1:0]      binOut,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [BIN_W-1:0] SAT_BIN   = BIN_W'(SAT_VAL);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // A nibble of 5..9 becomes 8..12 so the following shift carries into the next digit.
    function automatic logic [3:0] adjNibble(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    function automatic logic [BCD_W-1:0] adjScratch(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] res;
        res = s;
        for (int d = 0; d < DIGITS; d++) begin
            res[d*4 +: 4] = adjNibble(s[d*4 +: 4]);
        end
        return res;
    endfunction

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [BCD_W-1:0]  scratch_r;
    logic [BIN_W-1:0]  shift_r;
    logic [BIN_W-1:0]  sat_r;
    logic              ovf_r;

    logic              overInput_s;
    logic [BIN_W-1:0]  satIn_s;
    logic [BCD_W-1:0]  adjusted_s;
    logic [BCD_W-1:0]  stepScratch_s;
    logic [BIN_W-1:0]  stepShift_s;

    // Capture-time saturation and one add-3-then-shift step of the conversion engine.
    always_comb begin
        overInput_s   = 1'b0;
        satIn_s       = binIn;
        adjusted_s    = adjScratch(scratch_r);
        stepScratch_s = {adjusted_s[BCD_W-2:0], shift_r[BIN_W-1]};
        stepShift_s   = {shift_r[BIN_W-2:0], 1'b0};
        if (binIn > SAT_BIN) begin
            overInput_s = 1'b1;
            satIn_s     = SAT_BIN;
        end else begin
            overInput_s = 1'b0;
            satIn_s     = binIn;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            scratch_r <= '0;
            shift_r   <= '0;
            sat_r     <= '0;
            ovf_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcdOut    <= '0;
            binOut    <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        sat_r     <= satIn_s;
                        shift_r   <= satIn_s;
                        ovf_r     <= overInput_s;
                        scratch_r <= '0;
                        cnt_r     <= '0;
                        busy      <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    scratch_r <= stepScratch_s;
                    shift_r   <= stepShift_s;
                    cnt_r     <= cnt_r + CNT_ONE;
                    busy      <= 1'b1;
                    if (cnt_r == LAST_STEP) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    bcdOut   <= scratch_r;
                    binOut   <= sat_r;
                    overflow <= ovf_r;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed scenarios plus random values
// compared against an arithmetic decimal-digit reference.
module tb_bin_to_bcd_seq;

    logic        Clk;
    logic        nReset;
    logic [13:0] binIn;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] bcdOut;
    logic [13:0] binOut;
    logic        overflow;

    int total;
    int bad;

    bin_to_bcd_seq dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .binIn    (binIn),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bcdOut   (bcdOut),
        .binOut   (binOut),
        .overflow (overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int satOf(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] refBcd(input int v);
        int s;
        s = satOf(v);
        return 16'(((s / 1000) % 10) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + (s % 10));
    endfunction

    // Stimulus only: one start pulse, binIn scrambled after capture, wait (bounded) for done.
    task automatic convert(input int v, output int lat, output logic [15:0] b,
                           output logic [13:0] bo, output logic o, output logic busyEarly);
        @(negedge Clk);
        binIn = 14'(v);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        binIn = 14'($urandom);
        busyEarly = busy;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        b  = bcdOut;
        bo = binOut;
        o  = overflow;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        start  = 1'b0;
        binIn  = 14'd0;
        repeat (3) @(negedge Clk);
        total++;
        if ({busy, done, bcdOut, binOut, overflow} !== 33'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b bcd=%h bin=%0d ovf=%b, want all 0",
                     busy, done, bcdOut, binOut, overflow);
        end
        nReset = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_directed();
        int vals[7] = '{0, 9999, 200, 199, 12345, 42, 16383};
        int lat;
        logic [15:0] b;
        logic [13:0] bo;
        logic o, be;
        foreach (vals[i]) begin
            convert(vals[i], lat, b, bo, o, be);
            total++;
            if (lat !== 16) begin
                bad++;
                $display("FAIL dir_latency v=%0d: got %0d want 16", vals[i], lat);
            end
            total++;
            if (be !== 1'b1) begin
                bad++;
                $display("FAIL dir_busy_rise v=%0d: got %b want 1", vals[i], be);
            end
            total++;
            if (b !== refBcd(vals[i])) begin
                bad++;
                $display("FAIL dir_bcd v=%0d: got %h want %h", vals[i], b, refBcd(vals[i]));
            end
            total++;
            if (bo !== 14'(satOf(vals[i]))) begin
                bad++;
                $display("FAIL dir_bin v=%0d: got %0d want %0d", vals[i], bo, satOf(vals[i]));
            end
            total++;
            if (o !== (vals[i] > 9999)) begin
                bad++;
                $display("FAIL dir_ovf v=%0d: got %b want %b", vals[i], o, vals[i] > 9999);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, dones, lastDone, nextVal;
        @(negedge Clk);
        nextVal = 1;
        binIn = 14'd1;
        start = 1'b1;
        cyc = 0;
        dones = 0;
        lastDone = 0;
        while (dones < 3 && cyc < 80) begin
            @(negedge Clk);
            cyc++;
            if (done === 1'b1) begin
                total++;
                if (cyc - lastDone !== 16) begin
                    bad++;
                    $display("FAIL b2b_spacing: got %0d want 16", cyc - lastDone);
                end
                total++;
                if (bcdOut !== refBcd(nextVal)) begin
                    bad++;
                    $display("FAIL b2b_bcd: got %h want %h", bcdOut, refBcd(nextVal));
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_busy_done: got %b want 0", busy);
                end
                lastDone = cyc;
                dones++;
                nextVal++;
                binIn = 14'(nextVal);
                if (dones == 3) start = 1'b0;
            end else begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_busy_run cyc=%0d: got %b want 1", cyc, busy);
                end
            end
        end
        total++;
        if (dones !== 3) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d dones want 3", dones);
        end
        @(negedge Clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_after: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_ignore_while_busy();
        int cyc, dones;
        logic [15:0] firstBcd;
        @(negedge Clk);
        binIn = 14'd1234;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        binIn = 14'd777;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        cyc = 4;
        dones = 0;
        firstBcd = 16'hFFFF;
        while (cyc < 50) begin
            @(negedge Clk);
            cyc++;
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) firstBcd = bcdOut;
            end
        end
        total++;
        if (firstBcd !== refBcd(1234)) begin
            bad++;
            $display("FAIL busy_ignore_bcd: got %h want %h", firstBcd, refBcd(1234));
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL busy_ignore_count: got %0d dones want 1", dones);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [15:0] b;
        logic [13:0] bo;
        logic o, be, sawDone;
        convert(12345, lat, b, bo, o, be);
        @(negedge Clk);
        binIn = 14'd321;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (6) @(negedge Clk);
        #2 nReset = 1'b0;
        #1;
        total++;
        if ({busy, done, bcdOut, binOut, overflow} !== 33'd0) begin
            bad++;
            $display("FAIL async_reset_clear: got busy=%b done=%b bcd=%h bin=%0d ovf=%b, want all 0",
                     busy, done, bcdOut, binOut, overflow);
        end
        sawDone = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (done === 1'b1) sawDone = 1'b1;
        end
        nReset = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        total++;
        if (sawDone !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_abandon: got activity=%b want 0", sawDone);
        end
        convert(567, lat, b, bo, o, be);
        total++;
        if (lat !== 16 || b !== refBcd(567) || bo !== 14'd567 || o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_after: got lat=%0d bcd=%h bin=%0d ovf=%b want 16/%h/567/0",
                     lat, b, bo, o, refBcd(567));
        end
    endtask

    task automatic test_random();
        int lat, v;
        logic [15:0] b;
        logic [13:0] bo;
        logic o, be;
        for (int i = 0; i < 1500; i++) begin
            v = (i % 4 == 0) ? int'($urandom_range(16383, 9990)) : int'($urandom_range(16383, 0));
            convert(v, lat, b, bo, o, be);
            total++;
            if (lat !== 16 || b !== refBcd(v) || bo !== 14'(satOf(v)) || o !== (v > 9999)) begin
                bad++;
                $display("FAIL rand v=%0d: got lat=%0d bcd=%h bin=%0d ovf=%b want 16/%h/%0d/%b",
                         v, lat, b, bo, o, refBcd(v), satOf(v), v > 9999);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        nReset = 1'b0;
        start = 1'b0;
        binIn = 14'd0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_while_busy();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
